regfile_scb: RTL

//  Parametrised multi-read-port integer register file with an integrated pending-write scoreboard.

---
 rtl/regfile_scb.sv | 73 +++++++
 1 files changed

// File: rtl/regfile_scb.sv
// Multi-read-port register file with an integrated pending-write scoreboard.
// Reads are combinational with optional same-cycle write forwarding.
module regfile_scb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]    rbusy_o,
  input  logic              issue_i,
  input  logic [AW-1:0]     issue_rd_i,
  output logic [NREGS-1:0]  busy_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic             wr_ok_c;

  // A write is effective only for an existing, writable register.
  assign wr_ok_c = we_i && (32'(waddr_i) < NREGS)
                   && !((ZERO_REG != 0) && (waddr_i == '0));

  // Register array and scoreboard; a new issue outranks a same-cycle writeback.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        regs[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) begin
        if (wr_ok_c && (waddr_i == AW'(r))) begin
          regs[r] <= wdata_i;
        end
        if (issue_i && (issue_rd_i == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
          busy_q[r] <= 1'b1;
        end else if (we_i && (waddr_i == AW'(r))) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign busy_o = busy_q;

  // Read ports: array lookup, then forwarding of the in-flight write.
  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int k = 0; k < int'(NRD); k++) begin
      for (int r = 0; r < int'(NREGS); r++) begin
        if ((raddr_i[k*AW +: AW] == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
          rdata_o[k*XLEN +: XLEN] = regs[r];
          rbusy_o[k]              = busy_q[r];
        end
      end
      if ((BYPASS != 0) && wr_ok_c && (waddr_i == raddr_i[k*AW +: AW])) begin
        rdata_o[k*XLEN +: XLEN] = wdata_i;
        rbusy_o[k]              = 1'b0;
      end
    end
  end

endmodule
